// File: rtl/game_pkg.sv
// Shared definitions for the reaction-game controller and the speed timer it drives.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [1:0] SPEED_SLOW = 2'd0;  // 1.5 s round
  localparam logic [1:0] SPEED_MED  = 2'd1;  // 1.0 s round
  localparam logic [1:0] SPEED_FAST = 2'd2;  // 0.5 s round

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/game_level_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick target positions.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Maximal-length taps from a nonzero seed, so the all-zero lock-up state is never entered.
  always_comb begin
    q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= 8'h01;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/game_level_ctrl.sv
// Round/level controller for the whack-a-target game: lives, score, speed level and target choice.
module game_level_ctrl
  import game_pkg::*;
#(
  parameter int HITS_PER_LEVEL = 5,
  parameter int LIVES_INIT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] hit_btn,
  input  logic       timeout,
  output logic       en_out,
  output logic [1:0] speed,
  output logic [7:0] target,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       level_up,
  output logic       game_over
);

  localparam int HW = $clog2(HITS_PER_LEVEL + 1);

  state_e          state_q, state_d;
  logic            en_q, en_d;
  logic [1:0]      speed_q, speed_d;
  logic [7:0]      target_q, target_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic            level_up_q, level_up_d;
  logic            game_over_q, game_over_d;
  logic [HW-1:0]   hits_q, hits_d;

  logic [7:0]      lfsr;
  logic            lfsr_unused;
  logic            hit_ok;
  logic            miss;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:3];

  // A correct hit takes priority over a simultaneous timeout.
  assign hit_ok = (hit_btn == target_q);
  assign miss   = !hit_ok && ((hit_btn != 8'h00) || timeout);

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    speed_d    = speed_q;
    target_d   = target_q;
    score_d    = score_q;
    lives_d    = lives_q;
    hits_d     = hits_q;
    level_up_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_ARM;
          score_d  = 8'h00;
          lives_d  = 2'(LIVES_INIT);
          speed_d  = SPEED_SLOW;
          hits_d   = '0;
          target_d = 8'h00;
        end
      end
      ST_ARM: begin
        target_d = onehot8(lfsr[2:0]);
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (hit_ok) begin
          state_d = ST_ARM;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          if (hits_q == HW'(HITS_PER_LEVEL - 1)) begin
            hits_d = '0;
            if (speed_q != SPEED_FAST) begin
              speed_d    = speed_q + 2'd1;
              level_up_d = 1'b1;
            end
          end else begin
            hits_d = hits_q + HW'(1);
          end
        end else if (miss) begin
          if (lives_q <= 2'd1) begin
            lives_d  = 2'd0;
            target_d = 8'h00;
            state_d  = ST_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = ST_ARM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    en_d        = (state_d == ST_RUN);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      speed_q     <= SPEED_SLOW;
      target_q    <= 8'h00;
      score_q     <= 8'h00;
      lives_q     <= 2'd0;
      level_up_q  <= 1'b0;
      game_over_q <= 1'b0;
      hits_q      <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      speed_q     <= speed_d;
      target_q    <= target_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_up_q  <= level_up_d;
      game_over_q <= game_over_d;
      hits_q      <= hits_d;
    end
  end

  assign en_out    = en_q;
  assign speed     = speed_q;
  assign target    = target_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign level_up  = level_up_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_level_ctrl.sv
// Directed self-checking bench for game_level_ctrl with default parameters.
module tb_game_level_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       timeout = 1'b0;
  logic [7:0] hit_btn = 8'h00;
  logic       en_out;
  logic [1:0] speed;
  logic [7:0] target;
  logic [7:0] score;
  logic [1:0] lives;
  logic       level_up;
  logic       game_over;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_lfsr;
  logic [7:0] m_prev;
  logic [7:0] exp_tgt;
  logic [7:0] wrong;
  logic [1:0] exp_speed;

  game_level_ctrl #(
    .HITS_PER_LEVEL (5),
    .LIVES_INIT     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit_btn   (hit_btn),
    .timeout   (timeout),
    .en_out    (en_out),
    .speed     (speed),
    .target    (target),
    .score     (score),
    .lives     (lives),
    .level_up  (level_up),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev is the value that was visible during the previous cycle.
  always @(posedge clk) begin
    if (!rst) begin
      m_lfsr <= 8'h01;
      m_prev <= 8'h01;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    en_out,    0);
    check({tag, "_speed"}, speed,     0);
    check({tag, "_tgt"},   target,    0);
    check({tag, "_score"}, score,     0);
    check({tag, "_lives"}, lives,     0);
    check({tag, "_lvlup"}, level_up,  0);
    check({tag, "_over"},  game_over, 0);
  endtask

  task automatic enter_run();
    cyc();
    exp_tgt = 8'b1 << m_prev[2:0];
    wrong   = {exp_tgt[6:0], exp_tgt[7]};
    check("run_en",  en_out, 1);
    check("run_tgt", target, exp_tgt);
  endtask

  task automatic begin_game(input logic poke_in_arm);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("arm_en",    en_out,    0);
    check("arm_lives", lives,     3);
    check("arm_score", score,     0);
    check("arm_speed", speed,     0);
    check("arm_over",  game_over, 0);
    if (poke_in_arm) begin
      hit_btn = 8'hFF;
      timeout = 1'b1;
    end
    enter_run();
    hit_btn = 8'h00;
    timeout = 1'b0;
    check("run_lives", lives, 3);
  endtask

  task automatic press(input logic [7:0] b, input logic t);
    hit_btn = b;
    timeout = t;
    cyc();
    hit_btn = 8'h00;
    timeout = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    check_reset_outputs("rst");
    rst = 1'b1;
    cyc();

    // Inputs in IDLE are ignored
    press(8'hFF, 1'b1);
    check_reset_outputs("idle_ign");

    // Game 1: button/timeout during ARM ignored, then level progression
    begin_game(1'b1);
    for (int i = 1; i <= 20; i++) begin
      press(exp_tgt, 1'b0);
      exp_speed = (i >= 10) ? 2'd2 : (i >= 5) ? 2'd1 : 2'd0;
      check("hit_score", score,    i);
      check("hit_lvlup", level_up, (i == 5 || i == 10) ? 1 : 0);
      check("hit_speed", speed,    exp_speed);
      check("hit_arm_en", en_out,  0);
      enter_run();
      check("lvlup_drop", level_up, 0);
    end

    press(exp_tgt, 1'b1);
    check("hit_to_score", score, 21);
    check("hit_to_lives", lives, 3);
    enter_run();

    press(wrong, 1'b1);
    check("wrong_to_lives", lives, 2);
    check("wrong_to_score", score, 21);
    check("wrong_to_en",    en_out, 0);
    enter_run();

    press(exp_tgt | wrong, 1'b0);
    check("multi_lives", lives, 1);
    check("multi_score", score, 21);
    enter_run();

    press(8'h00, 1'b1);
    check("over_lives", lives,     0);
    check("over_flag",  game_over, 1);
    check("over_en",    en_out,    0);
    check("over_tgt",   target,    0);
    check("over_score", score,     21);

    press(8'h00, 1'b1);
    check("over_ign_lives", lives,     0);
    check("over_ign_flag",  game_over, 1);
    check("over_ign_score", score,     21);
    check("over_ign_en",    en_out,    0);

    // Game 2: three timeouts end the game
    begin_game(1'b0);
    press(8'h00, 1'b1);
    check("to1_lives", lives, 2);
    enter_run();
    press(8'h00, 1'b1);
    check("to2_lives", lives, 1);
    enter_run();
    press(8'h00, 1'b1);
    check("to3_lives", lives,     0);
    check("to3_over",  game_over, 1);
    check("to3_en",    en_out,    0);
    check("to3_score", score,     0);

    // Game 3: reset in the middle of a round
    begin_game(1'b0);
    for (int i = 1; i <= 7; i++) begin
      press(exp_tgt, 1'b0);
      enter_run();
    end
    check("pre_rst_score", score, 7);
    rst = 1'b0;
    cyc();
    check_reset_outputs("mid_rst");
    rst = 1'b1;
    cyc();
    begin_game(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
